// File: rtl/serial_paralelo_verde.sv
// Serial-to-parallel receiver with comma-based byte alignment.
// Shifts one bit per clk32_f edge (MSB first), hunts for the COMMA byte on a
// sliding window, confirms BC_LOCK consecutive aligned commas, then delivers
// every non-comma byte on data_out/valid_out for one byte period.
//
// Ports:
//   clk32_f   - bit-rate clock, all logic on its rising edge
//   reset     - synchronous, active-high reset
//   data_in   - serial bit stream, MSB of each byte first
//   data_out  - last received non-COMMA byte
//   valid_out - data_out holds a byte received in the current byte period
//   active    - alignment locked and BC_LOCK commas seen
module serial_paralelo_verde #(
  parameter logic [7:0]  COMMA   = 8'hBC,
  parameter int unsigned BC_LOCK = 4
) (
  input  logic       clk32_f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam int unsigned BC_W = (BC_LOCK > 1) ? $clog2(BC_LOCK + 1) : 1;
  localparam logic [BC_W-1:0] BC_TARGET = BC_W'(BC_LOCK);
  // With a lock count of one the first comma already completes the lock.
  localparam logic LOCK_ON_FIRST = (BC_LOCK <= 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      sr_q;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [BC_W-1:0] bc_cnt_q, bc_cnt_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            active_q;

  logic [7:0]      cur_byte_c;
  logic            is_comma_c;
  logic            byte_done_c;
  logic [BC_W-1:0] bc_inc_c;

  // Current byte includes the bit being sampled on this edge.
  assign cur_byte_c  = {sr_q[6:0], data_in};
  assign is_comma_c  = (cur_byte_c == COMMA);
  assign byte_done_c = (bit_cnt_q == 3'd7);
  assign bc_inc_c    = bc_cnt_q + BC_W'(1);

  // State and datapath registers.
  always_ff @(posedge clk32_f) begin
    if (reset) begin
      state_q   <= SEARCH;
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= '0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= cur_byte_c;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= (state_q == ACTIVE);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    case (state_q)
      SEARCH: begin
        // Sliding window: any bit position may start a byte.
        if (is_comma_c) begin
          bit_cnt_d = 3'd0;
          bc_cnt_d  = BC_W'(1);
          state_d   = LOCK_ON_FIRST ? ACTIVE : ALIGN;
        end
      end
      ALIGN: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (byte_done_c) begin
          if (is_comma_c) begin
            bc_cnt_d = bc_inc_c;
            if (bc_inc_c == BC_TARGET) begin
              state_d = ACTIVE;
            end
          end else begin
            bc_cnt_d = '0;
            state_d  = SEARCH;
          end
        end
      end
      ACTIVE: begin
        // Only byte-aligned windows are looked at; no exit short of reset.
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (byte_done_c) begin
          if (is_comma_c) begin
            valid_d = 1'b0;
          end else begin
            data_d  = cur_byte_c;
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = active_q;

endmodule
